gnr_ctrl: RTL and testbench

Controller for the boolean-network simulator. It loads an initial state into every node, steps the node array, and detects the attractor with Floyd tortoise/hare. Each node keeps two state copies: s0 is the tortoise and advances on every second `start_s0` pulse; s1 is the hare. gnr_ctrl drives the node array's control inputs, observes the gathered s0/s1 vectors, and reports the step count at first meeting and the attractor period.

---
 rtl/gnr_pkg.sv | 16 +
 rtl/gnr_vec_cmp.sv | 12 +
 rtl/gnr_ctrl.sv | 160 ++++++++++++++++
 tb/tb_gnr_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/gnr_pkg.sv
// Shared types and defaults for the boolean-network simulator controller.
package gnr_pkg;

  localparam int unsigned GNR_CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_CHECK,
    S_PSTEP,
    S_PCHECK,
    S_DONE
  } gnr_state_t;

endpackage

// File: rtl/gnr_vec_cmp.sv
// Combinational equality reducer over the gathered node state vectors.
module gnr_vec_cmp #(
  parameter int unsigned N_NODES = 8
) (
  input  logic [N_NODES-1:0] i_a,
  input  logic [N_NODES-1:0] i_b,
  output logic               o_eq
);

  assign o_eq = (i_a == i_b);

endmodule

// File: rtl/gnr_ctrl.sv
// Floyd tortoise/hare attractor detector driving the node array strobes.
module gnr_ctrl
  import gnr_pkg::*;
#(
  parameter int unsigned N_NODES = 8,
  parameter int unsigned CNT_W   = GNR_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_NODES-1:0] init_vec,
  input  logic [CNT_W-1:0]   max_steps,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   meet_steps,
  output logic [CNT_W-1:0]   period
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  gnr_state_t         r_state, w_nstate;
  logic [CNT_W-1:0]   r_k, w_k_nx;
  logic [CNT_W-1:0]   r_p, w_p_nx;
  logic [N_NODES-1:0] r_init, w_init_nx;
  logic               r_reset_nos, r_start_s0, r_start_s1, r_busy;
  logic               r_done, w_done_nx;
  logic               r_timeout, w_to_nx;
  logic [CNT_W-1:0]   r_meet, w_meet_nx;
  logic [CNT_W-1:0]   r_period, w_per_nx;
  logic               w_eq;
  logic [CNT_W-1:0]   w_k_inc, w_p_inc;
  logic               w_lim_k, w_lim_p;

  gnr_vec_cmp #(.N_NODES(N_NODES)) u_cmp (
    .i_a  (s0_vec),
    .i_b  (s1_vec),
    .o_eq (w_eq)
  );

  // Saturating increments and step-limit tests (max_steps == 0 is unlimited).
  assign w_k_inc = (r_k == '1) ? r_k : r_k + ONE;
  assign w_p_inc = (r_p == '1) ? r_p : r_p + ONE;
  assign w_lim_k = (max_steps != '0) && (r_k >= max_steps);
  assign w_lim_p = (max_steps != '0) && (r_p >= max_steps);

  // Next-state, counter and result update decode.
  always_comb begin
    w_nstate  = r_state;
    w_k_nx    = r_k;
    w_p_nx    = r_p;
    w_init_nx = r_init;
    w_done_nx = r_done;
    w_to_nx   = r_timeout;
    w_meet_nx = r_meet;
    w_per_nx  = r_period;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_init_nx = init_vec;
          w_done_nx = 1'b0;
          w_to_nx   = 1'b0;
          w_meet_nx = '0;
          w_per_nx  = '0;
          w_nstate  = S_LOAD;
        end
      end
      S_LOAD: begin
        w_k_nx   = '0;
        w_nstate = S_STEP;
      end
      S_STEP: begin
        w_k_nx   = w_k_inc;
        w_nstate = S_CHECK;
      end
      S_CHECK: begin
        if ((r_k >= TWO) && w_eq) begin
          w_meet_nx = r_k;
          w_p_nx    = '0;
          w_nstate  = S_PSTEP;
        end else if (w_lim_k) begin
          w_to_nx   = 1'b1;
          w_done_nx = 1'b1;
          w_nstate  = S_DONE;
        end else begin
          w_nstate = S_STEP;
        end
      end
      S_PSTEP: begin
        w_p_nx   = w_p_inc;
        w_nstate = S_PCHECK;
      end
      S_PCHECK: begin
        if (w_eq) begin
          w_per_nx  = r_p;
          w_done_nx = 1'b1;
          w_nstate  = S_DONE;
        end else if (w_lim_p) begin
          w_to_nx   = 1'b1;
          w_done_nx = 1'b1;
          w_nstate  = S_DONE;
        end else begin
          w_nstate = S_PSTEP;
        end
      end
      S_DONE:  w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // State, counters and registered outputs; strobes are decoded from the next state
  // so they are high during the cycle the FSM spends in LOAD/STEP/PSTEP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_p         <= '0;
      r_init      <= '0;
      r_reset_nos <= 1'b0;
      r_start_s0  <= 1'b0;
      r_start_s1  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_meet      <= '0;
      r_period    <= '0;
    end else begin
      r_state     <= w_nstate;
      r_k         <= w_k_nx;
      r_p         <= w_p_nx;
      r_init      <= w_init_nx;
      r_reset_nos <= (w_nstate == S_LOAD);
      r_start_s0  <= (w_nstate == S_STEP);
      r_start_s1  <= (w_nstate == S_STEP) || (w_nstate == S_PSTEP);
      r_busy      <= (w_nstate != S_IDLE) && (w_nstate != S_DONE);
      r_done      <= w_done_nx;
      r_timeout   <= w_to_nx;
      r_meet      <= w_meet_nx;
      r_period    <= w_per_nx;
    end
  end

  assign reset_nos  = r_reset_nos;
  assign init_state = r_init;
  assign start_s0   = r_start_s0;
  assign start_s1   = r_start_s1;
  assign busy       = r_busy;
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign meet_steps = r_meet;
  assign period     = r_period;

endmodule

// File: tb/tb_gnr_ctrl.sv
// Bench for gnr_ctrl: node-array model, trajectory-based reference, directed and random runs.
module tb_gnr_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  init_vec = '0;
  logic [15:0] max_steps = '0;
  logic        reset_nos, start_s0, start_s1, busy, done, timeout;
  logic [7:0]  init_state;
  logic [7:0]  s0_vec, s1_vec;
  logic [15:0] meet_steps, period;

  int checks = 0;
  int errors = 0;
  int mode = 0;
  logic [7:0] tbl [256];
  logic [7:0] seq [1200];
  logic       pass_flag;

  always #5 clk = ~clk;

  gnr_ctrl #(.N_NODES(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .init_vec   (init_vec),
    .max_steps  (max_steps),
    .reset_nos  (reset_nos),
    .init_state (init_state),
    .start_s0   (start_s0),
    .start_s1   (start_s1),
    .s0_vec     (s0_vec),
    .s1_vec     (s1_vec),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .meet_steps (meet_steps),
    .period     (period)
  );

  function automatic logic [7:0] nxt(input logic [7:0] x);
    case (mode)
      0:       return x;
      1:       return {x[7:2], x[1:0] + 2'd1};
      default: return tbl[x];
    endcase
  endfunction

  // Node array: tortoise advances on every second start_s0 pulse, starting with the first.
  always @(posedge clk) begin
    if (rst) begin
      s0_vec <= '0; s1_vec <= '0; pass_flag <= 1'b0;
    end else if (reset_nos) begin
      s0_vec <= init_state; s1_vec <= init_state; pass_flag <= 1'b1;
    end else begin
      if (start_s1) s1_vec <= nxt(s1_vec);
      if (start_s0) begin
        if (pass_flag) s0_vec <= nxt(s0_vec);
        pass_flag <= ~pass_flag;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the trajectory x[t]; tortoise sits at x[ceil(k/2)], hare at x[k].
  task automatic model(input logic [7:0] v, input int unsigned m,
                       output int unsigned em, output int unsigned ep, output int unsigned eto,
                       output int unsigned ecyc, output int unsigned es0, output int unsigned es1);
    int unsigned k, p;
    seq[0] = v;
    for (int i = 1; i < 1200; i++) seq[i] = nxt(seq[i-1]);
    k = 2;
    while (k < 900 && seq[(k+1)/2] != seq[k]) k++;
    p = 1;
    while (p < 290 && seq[k+p] != seq[k]) p++;
    if (m != 0 && k > m) begin
      em = 0; ep = 0; eto = 1; ecyc = 2*m + 2; es0 = m; es1 = m;
    end else if (m != 0 && p > m) begin
      em = k; ep = 0; eto = 1; ecyc = 2*k + 2*m + 2; es0 = k; es1 = k + m;
    end else begin
      em = k; ep = p; eto = 0; ecyc = 2*k + 2*p + 2; es0 = k; es1 = k + p;
    end
  endtask

  task automatic run(input string nm, input logic [7:0] v, input int unsigned m,
                     input int unsigned em, input int unsigned ep, input int unsigned eto,
                     input int unsigned ecyc, input int unsigned es0, input int unsigned es1,
                     input int unsigned pulse_at);
    int unsigned n, c_rn, c_s0, c_s1, viol;
    logic seen;
    @(negedge clk);
    start = 1'b1; init_vec = v; max_steps = 16'(m);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; c_rn = 0; c_s0 = 0; c_s1 = 0; viol = 0; seen = 1'b0;
    while (n < 4000 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({nm, "_load_rn"}, 32'(reset_nos), 1);
        chk({nm, "_load_busy"}, 32'(busy), 1);
        chk({nm, "_load_clr"}, {16'(done), 8'(timeout), 8'(meet_steps | period)}, 0);
        chk({nm, "_init_state"}, 32'(init_state), 32'(v));
        init_vec = 8'hFF;
      end
      if (n == pulse_at) start = 1'b1;
      else if (n == pulse_at + 1) start = 1'b0;
      c_rn += 32'(reset_nos); c_s0 += 32'(start_s0); c_s1 += 32'(start_s1);
      if ((reset_nos && start_s1) || (start_s0 && !start_s1)) viol++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, 32'(seen), 1);
    chk({nm, "_done_cycle"}, n, ecyc);
    chk({nm, "_meet"}, 32'(meet_steps), em);
    chk({nm, "_period"}, 32'(period), ep);
    chk({nm, "_timeout"}, 32'(timeout), eto);
    chk({nm, "_busy_at_done"}, 32'(busy), 0);
    chk({nm, "_n_reset_nos"}, c_rn, 1);
    chk({nm, "_n_s0"}, c_s0, es0);
    chk({nm, "_n_s1"}, c_s1, es1);
    chk({nm, "_strobe_excl"}, viol, 0);
    @(negedge clk);
    chk({nm, "_hold"}, {8'(done), 8'(busy), 8'(start_s1), 8'(reset_nos)}, 32'h01000000);
    chk({nm, "_hold_meet"}, 32'(meet_steps), em);
  endtask

  initial begin
    int unsigned em, ep, eto, ecyc, es0, es1, m, cnt;
    logic [7:0] v;
    logic found;

    repeat (3) @(negedge clk);
    chk("rst_outs", {8'(reset_nos), 8'(start_s0), 8'(start_s1), 8'(busy)}, 0);
    chk("rst_res", {8'(done), 8'(timeout), 16'(init_state)}, 0);
    chk("rst_cnt", {meet_steps, period}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_quiet", {8'(reset_nos), 8'(start_s1), 8'(busy), 8'(done)}, 0);

    mode = 0;
    run("fixpt", 8'h5A, 0, 2, 1, 0, 8, 2, 3, 0);
    mode = 1;
    run("mod4", 8'h00, 0, 8, 4, 0, 26, 8, 12, 0);
    run("mod4_to", 8'h00, 5, 0, 0, 1, 12, 5, 5, 0);
    run("busy_start", 8'h00, 0, 8, 4, 0, 26, 8, 12, 3);
    mode = 0;
    run("restart", 8'h33, 0, 2, 1, 0, 8, 2, 3, 0);
    mode = 1;
    run("mod4_lim8", 8'h04, 8, 8, 4, 0, 26, 8, 12, 0);
    run("mod4_lim2p", 8'h00, 3, 0, 0, 1, 8, 3, 3, 0);

    mode = 2;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++) tbl[i] = 8'($urandom);
      v = 8'($urandom);
      m = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0;
      model(v, m, em, ep, eto, ecyc, es0, es1);
      run($sformatf("rnd%0d", r), v, m, em, ep, eto, ecyc, es0, es1, 0);
    end

    mode = 1;
    @(negedge clk);
    start = 1'b1; init_vec = 8'h00; max_steps = '0;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0; cnt = 0;
    while (cnt < 100 && !found) begin
      @(negedge clk);
      cnt++;
      if (start_s1 && !start_s0) found = 1'b1;
    end
    chk("pstep_seen", 32'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outs", {8'(reset_nos), 8'(start_s0), 8'(start_s1), 8'(busy)}, 0);
    chk("midrst_res", {8'(done), 8'(timeout), 16'(init_state)}, 0);
    chk("midrst_cnt", {meet_steps, period}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {8'(reset_nos), 8'(start_s1), 8'(busy), 8'(done)}, 0);
    mode = 0;
    run("recover", 8'hC3, 0, 2, 1, 0, 8, 2, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
